// File: rtl/gamepad_pkg.sv
// Shared definitions for the Arduino pad bridge receiver: button code values
// and the debounce FSM state encoding.
package gamepad_pkg;

    localparam int unsigned CODE_NONE     = 0;
    localparam int unsigned CODE_CIRCLE   = 1;
    localparam int unsigned CODE_CROSS    = 2;
    localparam int unsigned CODE_SQUARE   = 3;
    localparam int unsigned CODE_TRIANGLE = 4;
    localparam int unsigned CODE_LEFT     = 5;
    localparam int unsigned CODE_RIGHT    = 6;
    localparam int unsigned CODE_UP       = 7;
    localparam int unsigned CODE_DOWN     = 8;
    localparam int unsigned CODE_R1       = 9;
    localparam int unsigned CODE_START    = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED
    } rx_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gamepad_debounce.sv
// Synchronises the raw code/select pins and accepts a pair once it has been
// stable for STABLE_CYCLES cycles. Exposes `locked` when PAD_AUTOREPEAT_EN is defined.
module gamepad_debounce
    import gamepad_pkg::*;
#(
    parameter int unsigned CODE_W        = 4,
    parameter int unsigned SEL_W         = 1,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CODE_W-1:0] gpio_code,
    input  logic [SEL_W-1:0]  gpio_sel,
    output logic              accept_stb,
`ifdef PAD_AUTOREPEAT_EN
    output logic              locked,
`endif
    output logic [CODE_W-1:0] pair_code,
    output logic [SEL_W-1:0]  pair_sel
);

    logic [CODE_W-1:0] sync1_code_q, sync1_code_d, s_code_q, s_code_d;
    logic [SEL_W-1:0]  sync1_sel_q, sync1_sel_d, s_sel_q, s_sel_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d, acc_code_q, acc_code_d;
    logic [SEL_W-1:0]  pend_sel_q, pend_sel_d, acc_sel_q, acc_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rx_state_e         state_q, state_d;
    logic              s_ne_pend, s_ne_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_code_q <= '0;
            sync1_sel_q  <= '0;
            s_code_q     <= '0;
            s_sel_q      <= '0;
            pend_code_q  <= '0;
            pend_sel_q   <= '0;
            acc_code_q   <= '0;
            acc_sel_q    <= '0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
        end else begin
            sync1_code_q <= sync1_code_d;
            sync1_sel_q  <= sync1_sel_d;
            s_code_q     <= s_code_d;
            s_sel_q      <= s_sel_d;
            pend_code_q  <= pend_code_d;
            pend_sel_q   <= pend_sel_d;
            acc_code_q   <= acc_code_d;
            acc_sel_q    <= acc_sel_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        sync1_code_d = gpio_code;
        sync1_sel_d  = gpio_sel;
        s_code_d     = sync1_code_q;
        s_sel_d      = sync1_sel_q;
        pend_code_d  = pend_code_q;
        pend_sel_d   = pend_sel_q;
        acc_code_d   = acc_code_q;
        acc_sel_d    = acc_sel_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        accept_stb   = 1'b0;
        s_ne_pend    = {s_code_q, s_sel_q} != {pend_code_q, pend_sel_q};
        s_ne_acc     = {s_code_q, s_sel_q} != {acc_code_q, acc_sel_q};

        case (state_q)
            ST_IDLE, ST_LOCKED: begin
                if (s_ne_acc) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = '0;
                    pend_code_d = s_code_q;
                    pend_sel_d  = s_sel_q;
                end
            end
            ST_SETTLE: begin
                if (s_ne_pend) begin
                    cnt_d       = '0;
                    pend_code_d = s_code_q;
                    pend_sel_d  = s_sel_q;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    // A pair that settles back onto the accepted one locks silently.
                    state_d    = ST_LOCKED;
                    acc_code_d = pend_code_q;
                    acc_sel_d  = pend_sel_q;
                    accept_stb = {pend_code_q, pend_sel_q} != {acc_code_q, acc_sel_q};
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pair_code = pend_code_q;
    assign pair_sel  = pend_sel_q;
`ifdef PAD_AUTOREPEAT_EN
    assign locked    = (state_q == ST_LOCKED);
`endif

endmodule

// File: rtl/gamepad_rx.sv
// Multi-channel pad receiver: decodes debounced code/select pairs into one-hot
// button vectors with press/release/error pulses. Auto-repeat via PAD_AUTOREPEAT_EN.
// `release` is a reserved word, so that output is named release_pulse.
module gamepad_rx
    import gamepad_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned NUM_BTN       = 10,
    parameter int unsigned CODE_W        = 4,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CODE_W-1:0]         gpio_code,
    input  logic [SEL_W-1:0]          gpio_sel,
    output logic [NUM_CH*NUM_BTN-1:0] btn,
    output logic [NUM_CH-1:0]         press,
    output logic [NUM_CH-1:0]         release_pulse,
    output logic                      err_code
);

`ifdef PAD_AUTOREPEAT_EN
    localparam int unsigned CNT_W = $clog2(max_u(STABLE_CYCLES, REPEAT_CYCLES)) + 1;
`else
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
`endif

    if (STABLE_CYCLES < 2) begin : g_chk_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if ((1 << CODE_W) <= NUM_BTN) begin : g_chk_code_w
        $error("CODE_W too narrow for NUM_BTN");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic                      accept_stb;
    logic [CODE_W-1:0]         pair_code;
    logic [SEL_W-1:0]          pair_sel;
    logic [NUM_CH*NUM_BTN-1:0] btn_q, btn_d;
    logic [NUM_CH-1:0]         press_q, press_d, release_q, release_d;
    logic                      err_q, err_d;
    logic                      code_ok, sel_ok;
    logic [NUM_BTN-1:0]        onehot;

`ifdef PAD_AUTOREPEAT_EN
    logic             locked;
    logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

    gamepad_debounce #(
        .CODE_W       (CODE_W),
        .SEL_W        (SEL_W),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .gpio_code (gpio_code),
        .gpio_sel  (gpio_sel),
        .accept_stb(accept_stb),
`ifdef PAD_AUTOREPEAT_EN
        .locked    (locked),
`endif
        .pair_code (pair_code),
        .pair_sel  (pair_sel)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            err_q     <= 1'b0;
        end else begin
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        btn_d     = btn_q;
        press_d   = '0;
        release_d = '0;
        err_d     = 1'b0;
        code_ok   = 32'(pair_code) <= NUM_BTN;
        sel_ok    = 32'(pair_sel) < NUM_CH;
        onehot    = NUM_BTN'(1) << (pair_code - CODE_W'(1));

        if (accept_stb) begin
            if (!sel_ok || !code_ok) begin
                err_d = 1'b1;
            end else if (pair_code == CODE_W'(CODE_NONE)) begin
                btn_d = '0;
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    release_d[c] = |btn_q[c*NUM_BTN +: NUM_BTN];
                end
            end else begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (32'(pair_sel) == c) begin
                        btn_d[c*NUM_BTN +: NUM_BTN] = onehot;
                        press_d[c] = btn_q[c*NUM_BTN +: NUM_BTN] != onehot;
                    end
                end
            end
        end

`ifdef PAD_AUTOREPEAT_EN
        // Repeat phase runs only while locked on a valid button; acceptance restarts it.
        rpt_d = '0;
        if (!accept_stb && locked && sel_ok && code_ok && pair_code != CODE_W'(CODE_NONE)) begin
            if (rpt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (32'(pair_sel) == c) begin
                        press_d[c] = 1'b1;
                    end
                end
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
`endif
    end

`ifdef PAD_AUTOREPEAT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign btn           = btn_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign err_code      = err_q;

endmodule

// File: tb/tb_gamepad_rx.sv
// Scoreboard bench for gamepad_rx with STABLE_CYCLES=4, REPEAT_CYCLES=10.
// Expected output events are queued per drive and checked every cycle at negedge.
module tb_gamepad_rx;
    import gamepad_pkg::*;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned NUM_BTN = 10;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned STABLE  = 4;
    localparam int unsigned REPEAT  = 10;
    // Drive at negedge -> edge 0 is next posedge; update lands on edge STABLE+2.
    localparam int unsigned LAT     = STABLE + 3;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [CODE_W-1:0]         gpio_code = '0;
    logic [0:0]                gpio_sel = '0;
    logic [NUM_CH*NUM_BTN-1:0] btn;
    logic [NUM_CH-1:0]         press;
    logic [NUM_CH-1:0]         release_pulse;
    logic                      err_code;

    typedef struct {
        int unsigned at;
        logic [19:0] btn;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [19:0] exp_btn = '0;
    bit          mon_en = 1'b0;
    int unsigned edge_n = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    gamepad_rx #(
        .NUM_CH       (NUM_CH),
        .NUM_BTN      (NUM_BTN),
        .CODE_W       (CODE_W),
        .STABLE_CYCLES(STABLE),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .gpio_code    (gpio_code),
        .gpio_sel     (gpio_sel),
        .btn          (btn),
        .press        (press),
        .release_pulse(release_pulse),
        .err_code     (err_code)
    );

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, act, exp, edge_n);
    endtask

    function automatic logic [19:0] bit_of(input int unsigned ch, input int unsigned code);
        return 20'(1) << (ch * NUM_BTN + code - 1);
    endfunction

    task automatic drive(input int unsigned sel, input int unsigned code);
        @(negedge clock);
        gpio_sel  = 1'(sel);
        gpio_code = 4'(code);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_evt(input int unsigned at, input logic [19:0] b,
                              input logic [1:0] p, input logic [1:0] r, input logic e);
        exp_t x;
        x.at = at; x.btn = b; x.press = p; x.rel = r; x.err = e;
        sb.push_back(x);
    endtask

    // Drive a pair, queue the single expected event, then let it settle.
    task automatic apply(input int unsigned sel, input int unsigned code, input logic [19:0] b,
                         input logic [1:0] p, input logic [1:0] r, input logic e);
        drive(sel, code);
        expect_evt(edge_n + LAT, b, p, r, e);
        idle(14);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].at == edge_n) begin
                cur = sb.pop_front();
                check_eq("evt_btn", 32'(btn), 32'(cur.btn));
                check_eq("evt_press", 32'(press), 32'(cur.press));
                check_eq("evt_release", 32'(release_pulse), 32'(cur.rel));
                check_eq("evt_err", 32'(err_code), 32'(cur.err));
                exp_btn = cur.btn;
            end else begin
                check_eq("hold_btn", 32'(btn), 32'(exp_btn));
                check_eq("no_pulse", 32'({press, release_pulse, err_code}), 32'(0));
            end
        end
    end

    initial begin
        #2;
        check_eq("rst_btn", 32'(btn), 32'(0));
        check_eq("rst_pulses", 32'({press, release_pulse, err_code}), 32'(0));
        @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(4);

        // Glitch held for 3 synchronised cycles: no output change.
        drive(0, CODE_SQUARE);
        repeat (2) @(negedge clock);
        drive(0, CODE_NONE);
        idle(14);

        apply(0, CODE_SQUARE, bit_of(0, 3), 2'b01, 2'b00, 1'b0);
        apply(1, CODE_START, bit_of(0, 3) | bit_of(1, 10), 2'b10, 2'b00, 1'b0);
        apply(1, CODE_NONE, 20'h0, 2'b00, 2'b11, 1'b0);
        apply(1, CODE_START, bit_of(1, 10), 2'b10, 2'b00, 1'b0);
        apply(0, CODE_LEFT, bit_of(1, 10) | bit_of(0, 5), 2'b01, 2'b00, 1'b0);
        apply(0, 12, bit_of(1, 10) | bit_of(0, 5), 2'b00, 2'b00, 1'b1);

        // Re-accepting the value ch0 already holds: no pulses, btn unchanged.
        drive(0, CODE_LEFT);
        idle(14);

        // Async reset while a new pair is settling.
        drive(0, CODE_UP);
        repeat (3) @(negedge clock);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_btn", 32'(btn), 32'(0));
        check_eq("async_rst_pulses", 32'({press, release_pulse, err_code}), 32'(0));
        gpio_code = '0;
        gpio_sel  = '0;
        @(negedge clock);
        check_eq("rst_hold_btn", 32'(btn), 32'(0));
        reset   = 1'b0;
        exp_btn = '0;
        mon_en  = 1'b1;
        idle(14);

        drive(0, CODE_CIRCLE);
        expect_evt(edge_n + LAT, bit_of(0, 1), 2'b01, 2'b00, 1'b0);
`ifdef PAD_AUTOREPEAT_EN
        for (int unsigned k = 1; k <= 3; k++) begin
            expect_evt(edge_n + LAT + k * REPEAT, bit_of(0, 1), 2'b01, 2'b00, 1'b0);
        end
`endif
        idle(42);

        check_eq("sb_drain", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
